// File: rtl/imm_prefix_splitter_pkg.sv
// Shared constants and state encoding for the immediate prefix encode/decode blocks.
package imm_prefix_splitter_pkg;

    localparam int DATA_W  = 16;
    localparam int FIELD_W = 12;
    localparam int PFX_W   = DATA_W - FIELD_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EMIT_PFX = 2'd1,
        EMIT_LOW = 2'd2
    } split_state_t;

endpackage

// File: rtl/imm_prefix_splitter.sv
// Splits an operand into an optional upper-bits prefix word followed by a low-field word.
module imm_prefix_splitter
    import imm_prefix_splitter_pkg::*;
#(
    parameter int DATA_W  = imm_prefix_splitter_pkg::DATA_W,
    parameter int FIELD_W = imm_prefix_splitter_pkg::FIELD_W,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  in_value,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [FIELD_W-1:0] out_field,
    output logic               out_is_prefix,
    output logic               out_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   words_sent
);

    localparam int UPPER_W = DATA_W - FIELD_W;

    split_state_t       state, state_d;
    logic [FIELD_W-1:0] low_q, low_d;
    logic [FIELD_W-1:0] field_d;
    logic               pfx_d, last_d, valid_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [UPPER_W-1:0] upper;

    assign in_ready = (state == IDLE);
    assign upper    = in_value[DATA_W-1:FIELD_W];

    always_comb begin
        state_d = state;
        low_d   = low_q;
        field_d = out_field;
        pfx_d   = out_is_prefix;
        last_d  = out_last;
        valid_d = out_valid;
        cnt_d   = words_sent + CNT_W'(out_valid && out_ready);

        case (state)
            IDLE: begin
                if (in_valid) begin
                    low_d   = in_value[FIELD_W-1:0];
                    valid_d = 1'b1;
                    if (upper != '0) begin
                        state_d                = EMIT_PFX;
                        field_d                = '0;
                        field_d[UPPER_W-1:0]   = upper;
                        pfx_d                  = 1'b1;
                        last_d                 = 1'b0;
                    end else begin
                        state_d = EMIT_LOW;
                        field_d = in_value[FIELD_W-1:0];
                        pfx_d   = 1'b0;
                        last_d  = 1'b1;
                    end
                end
            end
            EMIT_PFX: begin
                if (out_ready) begin
                    state_d = EMIT_LOW;
                    field_d = low_q;
                    pfx_d   = 1'b0;
                    last_d  = 1'b1;
                end
            end
            EMIT_LOW: begin
                if (out_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            low_q         <= '0;
            out_field     <= '0;
            out_is_prefix <= 1'b0;
            out_last      <= 1'b0;
            out_valid     <= 1'b0;
            words_sent    <= '0;
        end else begin
            state         <= state_d;
            low_q         <= low_d;
            out_field     <= field_d;
            out_is_prefix <= pfx_d;
            out_last      <= last_d;
            out_valid     <= valid_d;
            words_sent    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_imm_prefix_splitter.sv
// Directed self-checking bench for imm_prefix_splitter.
module tb_imm_prefix_splitter;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_value;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] out_field;
    logic        out_is_prefix;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] words_sent;

    int errors = 0;
    int checks = 0;

    imm_prefix_splitter #(.DATA_W(16), .FIELD_W(12), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_value(in_value), .in_valid(in_valid), .in_ready(in_ready),
        .out_field(out_field), .out_is_prefix(out_is_prefix), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .words_sent(words_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an operand for one accept edge; returns at the negedge after acceptance.
    task automatic send(input logic [15:0] v, input logic rdy);
        in_value  = v;
        in_valid  = 1'b1;
        out_ready = rdy;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_value = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_field !== 12'h000 || out_is_prefix !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL reset_fields: got %h/%b/%b want 000/0/0", out_field, out_is_prefix, out_last); end
        checks++; if (words_sent !== 16'h0000) begin errors++; $display("FAIL reset_count: got %h want 0000", words_sent); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_no_prefix;
        send(16'h0ABC, 1'b1);
        checks++; if (out_valid !== 1'b1 || out_field !== 12'hABC || out_is_prefix !== 1'b0 || out_last !== 1'b1) begin errors++; $display("FAIL nopfx_word: got v=%b f=%h p=%b l=%b want 1 abc 0 1", out_valid, out_field, out_is_prefix, out_last); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL nopfx_busy: got %b want 0", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL nopfx_idle: got v=%b r=%b want 0 1", out_valid, in_ready); end
        checks++; if (words_sent !== 16'd1) begin errors++; $display("FAIL nopfx_count: got %0d want 1", words_sent); end
    endtask

    task automatic test_prefix;
        send(16'h5123, 1'b1);
        checks++; if (out_valid !== 1'b1 || out_field !== 12'h005 || out_is_prefix !== 1'b1 || out_last !== 1'b0) begin errors++; $display("FAIL pfx_word1: got v=%b f=%h p=%b l=%b want 1 005 1 0", out_valid, out_field, out_is_prefix, out_last); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_field !== 12'h123 || out_is_prefix !== 1'b0 || out_last !== 1'b1) begin errors++; $display("FAIL pfx_word2: got v=%b f=%h p=%b l=%b want 1 123 0 1", out_valid, out_field, out_is_prefix, out_last); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL pfx_idle: got v=%b r=%b want 0 1", out_valid, in_ready); end
        checks++; if (words_sent !== 16'd3) begin errors++; $display("FAIL pfx_count: got %0d want 3", words_sent); end
    endtask

    task automatic test_stall;
        send(16'hF000, 1'b0);
        // keep offering a different operand; it must be ignored while busy
        in_value = 16'h1234; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1 || out_field !== 12'h00F || out_is_prefix !== 1'b1 || out_last !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL stall_hold%0d: got v=%b f=%h p=%b l=%b r=%b want 1 00f 1 0 0", i, out_valid, out_field, out_is_prefix, out_last, in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_field !== 12'h000 || out_is_prefix !== 1'b0 || out_last !== 1'b1) begin errors++; $display("FAIL stall_low: got v=%b f=%h p=%b l=%b want 1 000 0 1", out_valid, out_field, out_is_prefix, out_last); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || words_sent !== 16'd5) begin errors++; $display("FAIL stall_idle: got v=%b r=%b n=%0d want 0 1 5", out_valid, in_ready, words_sent); end
    endtask

    task automatic test_boundaries;
        send(16'h0000, 1'b1);
        checks++; if (out_valid !== 1'b1 || out_field !== 12'h000 || out_is_prefix !== 1'b0 || out_last !== 1'b1) begin errors++; $display("FAIL zero_word: got v=%b f=%h p=%b l=%b want 1 000 0 1", out_valid, out_field, out_is_prefix, out_last); end
        @(negedge clk);
        send(16'hFFFF, 1'b1);
        checks++; if (out_field !== 12'h00F || out_is_prefix !== 1'b1 || out_last !== 1'b0) begin errors++; $display("FAIL ones_pfx: got f=%h p=%b l=%b want 00f 1 0", out_field, out_is_prefix, out_last); end
        @(negedge clk);
        checks++; if (out_field !== 12'hFFF || out_is_prefix !== 1'b0 || out_last !== 1'b1) begin errors++; $display("FAIL ones_low: got f=%h p=%b l=%b want fff 0 1", out_field, out_is_prefix, out_last); end
        @(negedge clk);
        checks++; if (words_sent !== 16'd8) begin errors++; $display("FAIL bound_count: got %0d want 8", words_sent); end
    endtask

    task automatic test_async_reset;
        send(16'h7777, 1'b0);
        checks++; if (out_field !== 12'h007 || out_is_prefix !== 1'b1) begin errors++; $display("FAIL arst_pre: got f=%h p=%b want 007 1", out_field, out_is_prefix); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_field !== 12'h000 || out_is_prefix !== 1'b0 || out_last !== 1'b0 || words_sent !== 16'h0000) begin errors++; $display("FAIL arst_clear: got v=%b f=%h p=%b l=%b n=%0d want 0 000 0 0 0", out_valid, out_field, out_is_prefix, out_last, words_sent); end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || words_sent !== 16'h0000) begin errors++; $display("FAIL arst_after%0d: got v=%b r=%b n=%0d want 0 1 0", i, out_valid, in_ready, words_sent); end
        end
    endtask

    task automatic test_wrap;
        force dut.words_sent = 16'hFFFF;
        #1 release dut.words_sent;
        @(negedge clk);
        checks++; if (words_sent !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h want ffff", words_sent); end
        send(16'h0123, 1'b1);
        checks++; if (out_field !== 12'h123 || out_last !== 1'b1) begin errors++; $display("FAIL wrap_word: got f=%h l=%b want 123 1", out_field, out_last); end
        @(negedge clk);
        checks++; if (words_sent !== 16'h0000) begin errors++; $display("FAIL wrap_count: got %h want 0000", words_sent); end
    endtask

    initial begin
        test_reset;
        test_no_prefix;
        test_prefix;
        test_stall;
        test_boundaries;
        test_async_reset;
        test_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
